// File: rtl/register_file_sb_pkg.sv
// Shared project definitions for the register file slice.
// Default data width / register count used as parameter defaults by
// register_file_sb and its scoreboard. No types are defined here.
package register_file_sb_pkg;
  localparam int DATA_WIDTH_DEF       = 32;
  localparam int REG_DEPTH_DEF        = 32;
  localparam int DATA_INDEX_LIMIT     = DATA_WIDTH_DEF - 1;
  localparam int REG_ADDR_INDEX_LIMIT = $clog2(REG_DEPTH_DEF) - 1;
endpackage

// File: rtl/register_file_sb_scoreboard.sv
// reg_scoreboard_sb: one busy bit per register.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   resv_i, addr_resv_i     mark a register busy (producer issued)
//   write_i, addr_w_i       writeback, clears the busy bit
//   flush_i                 clear every busy bit
//   raddr_i[1:0]            read-port addresses for the lookups
//   busy_o[1:0]             pre-edge busy bit at each read address
//   nbusy_o[1:0]            post-edge busy bit at each read address
//   conflict_o              registered pulse: reservation hit a busy register
module reg_scoreboard_sb
  import register_file_sb_pkg::*;
#(
  parameter int DEPTH    = REG_DEPTH_DEF,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               resv_i,
  input  logic [AW-1:0]      addr_resv_i,
  input  logic               write_i,
  input  logic [AW-1:0]      addr_w_i,
  input  logic               flush_i,
  input  logic [1:0][AW-1:0] raddr_i,
  output logic [1:0]         busy_o,
  output logic [1:0]         nbusy_o,
  output logic               conflict_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic             resv_en;

  always_comb begin
    resv_en = resv_i && !(ZERO_REG != 0 && addr_resv_i == '0);
    busy_d  = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (write_i) busy_d[addr_w_i] = 1'b0;
      // Applied after the write clear: a new producer supersedes the retiring one.
      if (resv_en) busy_d[addr_resv_i] = 1'b1;
    end
    conflict_d = resv_en && busy_q[addr_resv_i] && !flush_i &&
                 !(write_i && addr_w_i == addr_resv_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      busy_o[p]  = busy_q[raddr_i[p]];
      nbusy_o[p] = busy_d[raddr_i[p]];
    end
  end

  assign conflict_o = conflict_q;

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: DEPTH x WIDTH register file, one write port, two
// registered read ports, optional write-to-read bypass, optional hardwired
// zero register, and a per-register busy scoreboard for RAW detection.
// Ports:
//   CLK, RST                      clock, async active-low reset
//   READ, ADDR_R1/R2              capture both read ports
//   DATA_R1/R2, BUSY_R1/R2        registered read data and busy status
//   WRITE, ADDR_W, DATA_W         writeback port
//   RESV, ADDR_RESV               reserve a destination register
//   FLUSH                         clear all busy bits
//   RESV_CONFLICT                 pulse: reservation hit a busy register
module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int WIDTH    = DATA_WIDTH_DEF,
  parameter int DEPTH    = REG_DEPTH_DEF,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             READ,
  input  logic [AW-1:0]    ADDR_R1,
  input  logic [AW-1:0]    ADDR_R2,
  output logic [WIDTH-1:0] DATA_R1,
  output logic [WIDTH-1:0] DATA_R2,
  output logic             BUSY_R1,
  output logic             BUSY_R2,
  input  logic             WRITE,
  input  logic [AW-1:0]    ADDR_W,
  input  logic [WIDTH-1:0] DATA_W,
  input  logic             RESV,
  input  logic [AW-1:0]    ADDR_RESV,
  input  logic             FLUSH,
  output logic             RESV_CONFLICT
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [1:0][WIDTH-1:0]       rd_data_q, rd_data_d;
  logic [1:0]                  rd_busy_q, rd_busy_d;
  logic [1:0][AW-1:0]          raddr;
  logic [1:0]                  sb_busy, sb_nbusy;
  logic                        wr_en;

  assign raddr = {ADDR_R2, ADDR_R1};
  assign wr_en = WRITE && !(ZERO_REG != 0 && ADDR_W == '0);

  reg_scoreboard_sb #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .resv_i      (RESV),
    .addr_resv_i (ADDR_RESV),
    .write_i     (WRITE),
    .addr_w_i    (ADDR_W),
    .flush_i     (FLUSH),
    .raddr_i     (raddr),
    .busy_o      (sb_busy),
    .nbusy_o     (sb_nbusy),
    .conflict_o  (RESV_CONFLICT)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[ADDR_W] <= DATA_W;
    end
  end

  // Read-port next state. The zero register wins over the bypass so a write
  // of non-zero data to address 0 can never leak onto a read port.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (READ) begin
      for (int p = 0; p < 2; p++) begin
        if (ZERO_REG != 0 && raddr[p] == '0) begin
          rd_data_d[p] = '0;
          rd_busy_d[p] = 1'b0;
        end else if (BYPASS != 0 && WRITE && ADDR_W == raddr[p]) begin
          // Busy follows the post-edge scoreboard state, so a same-cycle
          // reservation of this register still shows up as busy.
          rd_data_d[p] = DATA_W;
          rd_busy_d[p] = sb_nbusy[p];
        end else begin
          rd_data_d[p] = mem_q[raddr[p]];
          rd_busy_d[p] = sb_busy[p];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign DATA_R1 = rd_data_q[0];
  assign DATA_R2 = rd_data_q[1];
  assign BUSY_R1 = rd_busy_q[0];
  assign BUSY_R2 = rd_busy_q[1];

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb. Two instances share the stimulus:
//   cfg0: ZERO_REG=0, BYPASS=1 (defaults)
//   cfg1: ZERO_REG=1, BYPASS=0
// Each edge the reference model's expected outputs are pushed to a queue;
// a negedge monitor pops and compares against both instances.
module tb_register_file_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        READ, WRITE, RESV, FLUSH;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W, ADDR_RESV;
  logic [31:0] DATA_W;

  logic [1:0][31:0] od1, od2;
  logic [1:0]       ob1, ob2, ocf;

  always #5 CLK = ~CLK;

  register_file_sb dut0 (
    .CLK(CLK), .RST(RST), .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(od1[0]), .DATA_R2(od2[0]), .BUSY_R1(ob1[0]), .BUSY_R2(ob2[0]),
    .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESV(RESV),
    .ADDR_RESV(ADDR_RESV), .FLUSH(FLUSH), .RESV_CONFLICT(ocf[0])
  );

  register_file_sb #(.ZERO_REG(1), .BYPASS(0)) dut1 (
    .CLK(CLK), .RST(RST), .READ(READ), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
    .DATA_R1(od1[1]), .DATA_R2(od2[1]), .BUSY_R1(ob1[1]), .BUSY_R2(ob2[1]),
    .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESV(RESV),
    .ADDR_RESV(ADDR_RESV), .FLUSH(FLUSH), .RESV_CONFLICT(ocf[1])
  );

  typedef struct packed {
    logic [1:0][31:0] d1;
    logic [1:0][31:0] d2;
    logic [1:0]       b1;
    logic [1:0]       b2;
    logic [1:0]       cf;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] mm[2][32];
  logic        mb[2][32];
  int          checks = 0;
  int          errors = 0;

  function automatic bit zr(int c);
    return c == 1;
  endfunction

  function automatic bit byp(int c);
    return c == 0;
  endfunction

  task automatic chk(string nm, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d got %h want %h", nm, c, act, exp);
    end
  endtask

  // {busy, data} that a read of address a should capture at this edge.
  function automatic logic [32:0] rd_model(int c, logic [4:0] a, bit resv_ok);
    if (zr(c) && a == 0) return 33'd0;
    if (byp(c) && WRITE && ADDR_W == a)
      return {(!FLUSH && resv_ok && ADDR_RESV == a), DATA_W};
    return {mb[c][a], mm[c][a]};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        mm[c][i] = '0;
        mb[c][i] = 1'b0;
      end
    e = '0;
  endtask

  // Evaluate the current inputs against the model, then take one edge.
  task automatic step();
    exp_t        n;
    logic [32:0] r;
    bit          resv_ok;
    n = e;
    for (int c = 0; c < 2; c++) begin
      resv_ok = RESV && !(zr(c) && ADDR_RESV == 0);
      n.cf[c] = resv_ok && mb[c][ADDR_RESV] && !FLUSH &&
                !(WRITE && ADDR_W == ADDR_RESV);
      if (READ) begin
        r = rd_model(c, ADDR_R1, resv_ok);
        n.d1[c] = r[31:0]; n.b1[c] = r[32];
        r = rd_model(c, ADDR_R2, resv_ok);
        n.d2[c] = r[31:0]; n.b2[c] = r[32];
      end
      if (WRITE && !(zr(c) && ADDR_W == 0)) mm[c][ADDR_W] = DATA_W;
      if (FLUSH) begin
        for (int i = 0; i < 32; i++) mb[c][i] = 1'b0;
      end else begin
        if (WRITE) mb[c][ADDR_W] = 1'b0;
        if (resv_ok) mb[c][ADDR_RESV] = 1'b1;
      end
    end
    @(posedge CLK);
    e = n;
    q.push_back(n);
    #1;
  endtask

  task automatic cyc(bit rd, int a1, int a2, bit wr, int aw, logic [31:0] dw,
                     bit rs, int ar, bit fl);
    READ = rd; ADDR_R1 = 5'(a1); ADDR_R2 = 5'(a2);
    WRITE = wr; ADDR_W = 5'(aw); DATA_W = dw;
    RESV = rs; ADDR_RESV = 5'(ar); FLUSH = fl;
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic check_zero_outputs(string nm);
    for (int c = 0; c < 2; c++) begin
      chk({nm, "_d1"}, c, od1[c], 32'h0);
      chk({nm, "_d2"}, c, od2[c], 32'h0);
      chk({nm, "_b"},  c, {30'h0, ob2[c], ob1[c]}, 32'h0);
      chk({nm, "_cf"}, c, {31'h0, ocf[c]}, 32'h0);
    end
  endtask

  // Assert reset away from both edges, check outputs before any edge.
  task automatic do_reset();
    @(negedge CLK); #1;
    RST = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    model_clear();
    READ = 0; WRITE = 0; RESV = 0; FLUSH = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    idle();
  endtask

  always @(negedge CLK) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      for (int c = 0; c < 2; c++) begin
        chk("DATA_R1", c, od1[c], x.d1[c]);
        chk("DATA_R2", c, od2[c], x.d2[c]);
        chk("BUSY_R1", c, {31'h0, ob1[c]}, {31'h0, x.b1[c]});
        chk("BUSY_R2", c, {31'h0, ob2[c]}, {31'h0, x.b2[c]});
        chk("RESV_CONFLICT", c, {31'h0, ocf[c]}, {31'h0, x.cf[c]});
      end
    end
  end

  initial begin
    RST = 1'b0;
    READ = 0; WRITE = 0; RESV = 0; FLUSH = 0;
    ADDR_R1 = 0; ADDR_R2 = 0; ADDR_W = 0; ADDR_RESV = 0; DATA_W = 0;
    model_clear();
    #2;
    check_zero_outputs("por");
    @(negedge CLK);
    RST = 1'b1;
    #1;
    idle();

    // write then read, 1-cycle latency, then hold with READ=0
    cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc(1, 5, 5, 0, 0, 32'h0, 0, 0, 0);
    cyc(0, 1, 2, 1, 5, 32'h0BADF00D, 0, 0, 0);
    idle();
    // bypass vs. old value
    cyc(0, 0, 0, 1, 7, 32'h00001111, 0, 0, 0);
    cyc(1, 7, 7, 1, 7, 32'h00001234, 0, 0, 0);
    cyc(1, 7, 5, 0, 0, 32'h0, 0, 0, 0);
    // scoreboard set / clear / same-cycle resv+write
    cyc(0, 0, 0, 0, 0, 32'h0, 1, 9, 0);
    cyc(1, 9, 9, 0, 0, 32'h0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    cyc(1, 9, 9, 0, 0, 32'h0, 0, 0, 0);
    cyc(1, 9, 1, 1, 9, 32'h999, 1, 9, 0);
    cyc(1, 9, 9, 0, 0, 32'h0, 0, 0, 0);
    // conflict pulse, then flush suppresses it
    cyc(0, 0, 0, 0, 0, 32'h0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 32'h0, 1, 3, 0);
    idle();
    cyc(1, 3, 9, 0, 0, 32'h0, 1, 3, 1);
    cyc(1, 3, 9, 0, 0, 32'h0, 0, 0, 0);
    // register 0
    cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 32'hA5A5A5A5, 0, 0, 0);
    idle();
    // mid-run reset, then reads come back as zero
    cyc(0, 0, 0, 1, 12, 32'hCAFEF00D, 1, 13, 0);
    do_reset();
    cyc(1, 5, 13, 0, 0, 32'h0, 0, 0, 0);
    cyc(1, 12, 9, 0, 0, 32'h0, 0, 0, 0);

    // randomized traffic on a narrow address range to provoke hits
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 7),
          $urandom_range(0, 15) == 0);
      if (i == 300) do_reset();
    end
    idle();
    @(negedge CLK); #1;
    chk("queue_drained", 0, q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
